// File: rtl/agregador_pkg.sv
// Shared types and constants for the period aggregator.
//   estado_agregador_t : campaign FSM states
//   PERIODO_W          : width of one period sample / result
//   MIN_INICIAL        : seed for the running minimum at campaign start
package agregador_pkg;

   localparam int PERIODO_W = 32;
   localparam logic [PERIODO_W-1:0] MIN_INICIAL = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      OCIOSO,
      COLETANDO,
      CALCULANDO,
      RESULTADO,
      ERRO
   } estado_agregador_t;

endpackage

// File: rtl/acumulador_periodos.sv
// Running sum / minimum / maximum of captured period samples.
//   clk, rst : clock, asynchronous active-high reset (everything to 0)
//   clear    : start a new campaign (sum=0, min=MIN_INICIAL, max=0)
//   capture  : accumulate value this cycle
//   value    : sample to accumulate
//   sum      : running sum, LOG2_AMOSTRAS extra bits so 2^LOG2_AMOSTRAS
//              full-scale samples never overflow
//   min, max : running extremes; constant 0 unless AGREGADOR_MINMAX_EN
//              is defined, in which case the trackers are built
module acumulador_periodos
   import agregador_pkg::*;
#(
   parameter int LOG2_AMOSTRAS = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               clear,
   input  logic                               capture,
   input  logic [PERIODO_W-1:0]               value,
   output logic [PERIODO_W+LOG2_AMOSTRAS-1:0] sum,
   output logic [PERIODO_W-1:0]               min,
   output logic [PERIODO_W-1:0]               max
);

   localparam int SOMA_W = PERIODO_W + LOG2_AMOSTRAS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sum <= '0;
      else if (clear)
         sum <= '0;
      else if (capture)
         sum <= sum + SOMA_W'(value);
   end

`ifdef AGREGADOR_MINMAX_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min <= '0;
         max <= '0;
      end else if (clear) begin
         min <= MIN_INICIAL;
         max <= '0;
      end else if (capture) begin
         if (value < min) min <= value;
         if (value > max) max <= value;
      end
   end
`else
   assign min = '0;
   assign max = '0;
`endif

endmodule

// File: rtl/agregador_de_periodos.sv
// Period aggregator: runs a campaign of 2^LOG2_AMOSTRAS measurements from an
// upstream period counter and reports their truncated average (and, with
// AGREGADOR_MINMAX_EN defined, the minimum and maximum).
//   clk, rst      : clock, asynchronous active-high reset
//   iniciar       : start a campaign (honoured only while ready_o)
//   ack           : acknowledge a result or a timeout
//   start_o       : enables the upstream counter while collecting
//   done_i        : one-cycle pulse, measurement finished
//   periodo_ms_i  : measured period, valid the cycle after done_i
//   ready_o       : idle
//   valid_o       : media_ms/min_ms/max_ms hold a finished result
//   timeout_o     : campaign aborted, more than CICLOS_TIMEOUT cycles
//                   without a sample
//   media_ms, min_ms, max_ms : results
// Optional feature macro: AGREGADOR_MINMAX_EN (min/max tracking).
module agregador_de_periodos
   import agregador_pkg::*;
#(
   parameter int LOG2_AMOSTRAS  = 3,
   parameter int CICLOS_TIMEOUT = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iniciar,
   input  logic                 ack,
   output logic                 start_o,
   input  logic                 done_i,
   input  logic [PERIODO_W-1:0] periodo_ms_i,
   output logic                 ready_o,
   output logic                 valid_o,
   output logic                 timeout_o,
   output logic [PERIODO_W-1:0] media_ms,
   output logic [PERIODO_W-1:0] min_ms,
   output logic [PERIODO_W-1:0] max_ms
);

   localparam int N      = 1 << LOG2_AMOSTRAS;
   localparam int CONT_W = LOG2_AMOSTRAS + 1;
   localparam int SOMA_W = PERIODO_W + LOG2_AMOSTRAS;
   localparam logic [CONT_W-1:0] CONT_ULTIMA = CONT_W'(N - 1);
   localparam logic [31:0]       TIMEOUT_FIM = 32'(CICLOS_TIMEOUT - 1);

   estado_agregador_t estado, prox;

   logic              done_d;
   logic [CONT_W-1:0] contagem;
   logic [31:0]       ciclos;
   logic [SOMA_W-1:0] soma;
   logic              limpar, captura, ultima, estourou;

   // periodo_ms_i is only valid one cycle after done_i, hence capture on done_d
   assign limpar   = (estado == OCIOSO) && iniciar;
   assign captura  = (estado == COLETANDO) && done_d;
   assign ultima   = captura && (contagem == CONT_ULTIMA);
   // a capture on the terminal cycle restarts the window instead of aborting
   assign estourou = (estado == COLETANDO) && !captura && (ciclos == TIMEOUT_FIM);

   always_comb begin
      prox      = estado;
      start_o   = 1'b0;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      timeout_o = 1'b0;
      case (estado)
         OCIOSO: begin
            ready_o = 1'b1;
            if (iniciar) prox = COLETANDO;
         end
         COLETANDO: begin
            start_o = 1'b1;
            if (ultima)        prox = CALCULANDO;
            else if (estourou) prox = ERRO;
         end
         CALCULANDO: prox = RESULTADO;
         RESULTADO: begin
            valid_o = 1'b1;
            if (ack) prox = OCIOSO;
         end
         ERRO: begin
            timeout_o = 1'b1;
            if (ack) prox = OCIOSO;
         end
         default: prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado   <= OCIOSO;
         done_d   <= 1'b0;
         contagem <= '0;
         ciclos   <= '0;
         media_ms <= '0;
      end else begin
         estado <= prox;
         // outside COLETANDO done_d is held at 0, so it is clean on entry
         done_d <= (estado == COLETANDO) ? done_i : 1'b0;
         if (limpar) begin
            contagem <= '0;
            ciclos   <= '0;
         end else if (estado == COLETANDO) begin
            if (captura) begin
               contagem <= contagem + 1'b1;
               ciclos   <= '0;
            end else begin
               ciclos <= ciclos + 32'd1;
            end
         end
         if (estado == CALCULANDO)
            media_ms <= PERIODO_W'(soma >> LOG2_AMOSTRAS);
      end
   end

   acumulador_periodos #(
      .LOG2_AMOSTRAS(LOG2_AMOSTRAS)
   ) u_acumulador (
      .clk     (clk),
      .rst     (rst),
      .clear   (limpar),
      .capture (captura),
      .value   (periodo_ms_i),
      .sum     (soma),
      .min     (min_ms),
      .max     (max_ms)
   );

endmodule

// File: tb/tb_agregador_de_periodos.sv
// Bench for agregador_de_periodos: instance 0 averages 8 samples, instance 1
// averages 4; both abort after 100 idle cycles.
module tb_agregador_de_periodos;

   logic        clk = 1'b0;
   logic        rst;
   logic        iniciar[2], ack[2], done_i[2];
   logic [31:0] periodo[2];
   logic        start_o[2], ready_o[2], valid_o[2], timeout_o[2];
   logic [31:0] media[2], mn[2], mx[2];
   logic [31:0] ultima_media[2];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   agregador_de_periodos #(.LOG2_AMOSTRAS(3), .CICLOS_TIMEOUT(100)) dut_a (
      .clk(clk), .rst(rst), .iniciar(iniciar[0]), .ack(ack[0]),
      .start_o(start_o[0]), .done_i(done_i[0]), .periodo_ms_i(periodo[0]),
      .ready_o(ready_o[0]), .valid_o(valid_o[0]), .timeout_o(timeout_o[0]),
      .media_ms(media[0]), .min_ms(mn[0]), .max_ms(mx[0]));

   agregador_de_periodos #(.LOG2_AMOSTRAS(2), .CICLOS_TIMEOUT(100)) dut_b (
      .clk(clk), .rst(rst), .iniciar(iniciar[1]), .ack(ack[1]),
      .start_o(start_o[1]), .done_i(done_i[1]), .periodo_ms_i(periodo[1]),
      .ready_o(ready_o[1]), .valid_o(valid_o[1]), .timeout_o(timeout_o[1]),
      .media_ms(media[1]), .min_ms(mn[1]), .max_ms(mx[1]));

   typedef struct {
      logic [31:0] amostras[8];
      logic [31:0] media;
      logic [31:0] mn;
      logic [31:0] mx;
   } vetor_t;

   vetor_t tabela[6];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nome, got, exp);
   endtask

   // Reference: plain arithmetic over the whole sample list.
   function automatic void modelo(input logic [31:0] q[$], output logic [31:0] med,
                                  output logic [31:0] lo, output logic [31:0] hi);
      longint unsigned s = 0;
      lo = 32'hFFFF_FFFF;
      hi = 0;
      foreach (q[i]) begin
         s += q[i];
         if (q[i] < lo) lo = q[i];
         if (q[i] > hi) hi = q[i];
      end
      med = 32'(s / longint'(q.size()));
   endfunction

   // One sample: done pulse (with junk on the bus), then the real value.
   task automatic amostra(input int s, input logic [31:0] v);
      done_i[s]  = 1'b1;
      periodo[s] = $urandom;
      tick();
      done_i[s]  = 1'b0;
      periodo[s] = v;
      tick();
      periodo[s] = $urandom;
   endtask

   // Full campaign ending in RESULTADO; sujo adds stray done/iniciar activity.
   task automatic campanha(input int s, input logic [31:0] q[$], input int gap_max,
                           input bit sujo, input logic [31:0] em, input logic [31:0] emn,
                           input logic [31:0] emx, input string nome);
      logic [31:0] emn_r, emx_r;
`ifdef AGREGADOR_MINMAX_EN
      emn_r = emn;
      emx_r = emx;
`else
      emn_r = 0;
      emx_r = 0;
`endif
      if (sujo) begin
         repeat (2) begin
            done_i[s] = 1'b1; periodo[s] = $urandom; tick();
            done_i[s] = 1'b0; tick();
         end
         done_i[s] = 1'b1;
      end
      iniciar[s] = 1'b1;
      tick();
      iniciar[s] = sujo;
      done_i[s]  = 1'b0;
      chk({nome, " start_o"}, 32'(start_o[s]), 1);
      foreach (q[i]) begin
         repeat ($urandom_range(gap_max, 0)) tick();
         amostra(s, q[i]);
      end
      iniciar[s] = 1'b0;
      chk({nome, " valid before latency"}, 32'(valid_o[s]), 0);
      tick();
      chk({nome, " valid at latency"}, 32'(valid_o[s]), 1);
      chk({nome, " media"}, media[s], em);
      chk({nome, " min"}, mn[s], emn_r);
      chk({nome, " max"}, mx[s], emx_r);
      ultima_media[s] = em;
   endtask

   task automatic reconhecer(input int s, input string nome);
      ack[s] = 1'b1;
      tick();
      ack[s] = 1'b0;
      chk({nome, " ready after ack"}, 32'(ready_o[s]), 1);
   endtask

   initial begin
      logic [31:0] q[$];
      logic [31:0] em, emn, emx;

      tabela[0] = '{'{10, 20, 30, 40, 50, 60, 70, 80}, 45, 10, 80};
      tabela[1] = '{'{5, 5, 5, 5, 5, 5, 5, 5}, 5, 5, 5};
      tabela[2] = '{'{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tabela[3] = '{'{0, 0, 0, 0, 0, 0, 0, 7}, 0, 0, 7};
      tabela[4] = '{'{8, 7, 6, 5, 4, 3, 2, 1}, 4, 1, 8};
      tabela[5] = '{'{32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0}, 32'h2000_0000, 0, 32'hFFFF_FFFF};

      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         iniciar[s] = 0; ack[s] = 0; done_i[s] = 0; periodo[s] = 0; ultima_media[s] = 0;
      end
      tick();
      tick();
      for (int s = 0; s < 2; s++) begin
         chk("reset ready", 32'(ready_o[s]), 1);
         chk("reset start", 32'(start_o[s]), 0);
         chk("reset valid", 32'(valid_o[s]), 0);
         chk("reset timeout", 32'(timeout_o[s]), 0);
         chk("reset media", media[s], 0);
         chk("reset min", mn[s], 0);
         chk("reset max", mx[s], 0);
      end
      rst = 1'b0;
      tick();

      // table vectors, 8-sample instance
      for (int i = 0; i < 6; i++) begin
         q = {};
         for (int k = 0; k < 8; k++) q.push_back(tabela[i].amostras[k]);
         campanha(0, q, 2, 1'b0, tabela[i].media, tabela[i].mn, tabela[i].mx,
                  $sformatf("tab%0d", i));
         reconhecer(0, $sformatf("tab%0d", i));
      end

      // 4-sample instance: truncation and result hold
      q = {1, 1, 1, 2};
      campanha(1, q, 0, 1'b0, 1, 1, 2, "trunc");
      repeat (5) begin
         tick();
         chk("hold valid", 32'(valid_o[1]), 1);
         chk("hold media", media[1], 1);
      end
      reconhecer(1, "trunc");
      chk("trunc valid after ack", 32'(valid_o[1]), 0);

      // timeout: a capture on the terminal cycle wins, then silence aborts
      iniciar[0] = 1'b1; tick(); iniciar[0] = 1'b0;
      amostra(0, 7);
      repeat (98) tick();
      done_i[0] = 1'b1; tick();
      done_i[0] = 1'b0; periodo[0] = 9; tick();
      chk("capture beats timeout", 32'(timeout_o[0]), 0);
      chk("still collecting", 32'(start_o[0]), 1);
      repeat (99) tick();
      chk("timeout edge-1", 32'(timeout_o[0]), 0);
      tick();
      chk("timeout edge", 32'(timeout_o[0]), 1);
      chk("timeout start_o", 32'(start_o[0]), 0);
      chk("timeout valid_o", 32'(valid_o[0]), 0);
      chk("timeout media held", media[0], ultima_media[0]);
      tick();
      chk("timeout held", 32'(timeout_o[0]), 1);
      reconhecer(0, "timeout");

      // reset mid-campaign
      iniciar[0] = 1'b1; tick(); iniciar[0] = 1'b0;
      amostra(0, 100); amostra(0, 200); amostra(0, 300);
      rst = 1'b1;
      #1;
      chk("async rst ready", 32'(ready_o[0]), 1);
      chk("async rst start", 32'(start_o[0]), 0);
      chk("async rst media", media[0], 0);
      chk("async rst min", mn[0], 0);
      chk("async rst max", mx[0], 0);
      tick();
      rst = 1'b0;
      ultima_media[0] = 0; ultima_media[1] = 0;
      tick();
      chk("post rst valid", 32'(valid_o[0]), 0);
      chk("post rst timeout", 32'(timeout_o[0]), 0);
      q = {5, 5, 5, 5, 5, 5, 5, 5};
      campanha(0, q, 1, 1'b0, 5, 5, 5, "after rst");
      reconhecer(0, "after rst");

      // stray done/iniciar activity
      q = {10, 20, 30, 40, 50, 60, 70, 80};
      campanha(0, q, 1, 1'b1, 45, 10, 80, "stray");
      repeat (2) begin
         done_i[0] = 1'b1; periodo[0] = 32'hDEAD; tick();
         done_i[0] = 1'b0; tick();
         chk("stray valid", 32'(valid_o[0]), 1);
         chk("stray media", media[0], 45);
      end
      iniciar[0] = 1'b1; ack[0] = 1'b1; tick();
      iniciar[0] = 1'b0; ack[0] = 1'b0;
      chk("iniciar with ack ignored", 32'(ready_o[0]), 1);
      tick();
      chk("no restart", 32'(start_o[0]), 0);

      // randomized campaigns against the model
      for (int r = 0; r < 12; r++) begin
         int s;
         s = r % 2;
         q = {};
         for (int k = 0; k < (s == 0 ? 8 : 4); k++)
            q.push_back((r % 3 == 0) ? $urandom : $urandom_range(1000, 0));
         modelo(q, em, emn, emx);
         campanha(s, q, 4, r % 4 == 1, em, emn, emx, $sformatf("rand%0d", r));
         reconhecer(s, $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/agregador_de_periodos.md
AGREGADOR_DE_PERIODOS -- requirements
Module: agregador_de_periodos

Interface
REQ-001 The block SHALL have parameter LOG2_AMOSTRAS, default 3, meaning log2 of the samples averaged per campaign (N = 2^LOG2_AMOSTRAS, legal range 0..8).
REQ-002 The block SHALL have parameter CICLOS_TIMEOUT, default 50_000_000, meaning the maximum clk cycles allowed between consecutive samples.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port iniciar, input, 1 bit: campaign start request.
REQ-006 The block SHALL have port ack, input, 1 bit: acknowledges the result or error.
REQ-007 The block SHALL have port start_o, output, 1 bit: drives the upstream period counter's start.
REQ-008 The block SHALL have port done_i, input, 1 bit: one-cycle measurement-complete pulse from the period counter.
REQ-009 The block SHALL have port periodo_ms_i, input, 32 bits: measured period, valid from the cycle after done_i.
REQ-010 The block SHALL have port ready_o, output, 1 bit: idle and accepting iniciar.
REQ-011 The block SHALL have port valid_o, output, 1 bit: result available.
REQ-012 The block SHALL have port timeout_o, output, 1 bit: campaign aborted on timeout.
REQ-013 The block SHALL have ports media_ms, min_ms and max_ms, each output, 32 bits: average, minimum and maximum period.

Function
REQ-014 The FSM SHALL have states OCIOSO, COLETANDO, CALCULANDO, RESULTADO and ERRO.
REQ-015 In OCIOSO the block SHALL drive ready_o=1; iniciar=1 SHALL cause a move to COLETANDO and clear: sum, sample count, timeout counter, max to 0, min to 32'hFFFF_FFFF.
REQ-016 In COLETANDO the block SHALL drive start_o=1, register done_i into done_d, and capture periodo_ms_i on the cycle done_d=1.
REQ-017 On each capture the block SHALL add the sample to a (32+LOG2_AMOSTRAS)-bit sum that never overflows, increment the count, update min/max, and clear the timeout counter.
REQ-018 The capture that brings the count to N SHALL cause a move to CALCULANDO on the next edge.
REQ-019 In COLETANDO the timeout counter SHALL increment every cycle; reaching CICLOS_TIMEOUT-1 without a capture SHALL cause a move to ERRO.
REQ-020 If a capture and the timeout terminal value occur in the same cycle, the capture SHALL win and no timeout SHALL occur.
REQ-021 CALCULANDO SHALL last exactly one cycle and register media_ms = sum >> LOG2_AMOSTRAS (truncating) before moving to RESULTADO.
REQ-022 In RESULTADO the block SHALL drive valid_o=1 and hold media_ms/min_ms/max_ms stable until ack=1, then move to OCIOSO.
REQ-023 In ERRO the block SHALL drive timeout_o=1 and hold the result outputs unchanged until ack=1, then move to OCIOSO.
REQ-024 iniciar SHALL be ignored outside OCIOSO, including a cycle in which ack returns the FSM to OCIOSO.
REQ-025 done_i pulses arriving outside COLETANDO SHALL be ignored, and done_d SHALL be cleared on entry to COLETANDO.
REQ-026 Latency SHALL be: valid_o rises 3 cycles after the cycle in which the N-th done_i is high.
REQ-027 start_o SHALL be 0 in every state other than COLETANDO.

Reset
REQ-028 rst=1 SHALL asynchronously force OCIOSO; start_o, valid_o and timeout_o to 0; ready_o to 1; media_ms, min_ms, max_ms, sum, count, done_d and the timeout counter to 0.
REQ-029 Reset asserted mid-campaign SHALL discard all partial accumulation, with no valid_o or timeout_o pulse on release.

Configuration
REQ-030 Macro AGREGADOR_MINMAX_EN defined SHALL compile in min/max tracking as specified above.
REQ-031 Without AGREGADOR_MINMAX_EN, min_ms and max_ms SHALL be constant 0 and no min/max registers SHALL be synthesized.

Structure
REQ-032 Package agregador_pkg SHALL hold the estado_agregador_t enum, the 32-bit period width constant, and the MIN_INICIAL = 32'hFFFF_FFFF constant.
REQ-033 Min/max/sum accumulation SHALL live in sub-module acumulador_periodos (inputs: clear, capture, value; outputs: sum, min, max); the FSM and timeout logic SHALL stay in the top level.

Verification
REQ-034 LOG2_AMOSTRAS=3, samples 10,20,30,40,50,60,70,80 -> valid_o=1, media_ms=45, min_ms=10, max_ms=80.
REQ-035 LOG2_AMOSTRAS=2, samples 1,1,1,2 -> media_ms=1 (truncation); valid_o held across 5 cycles of ack=0, and ready_o=1 the cycle after ack.
REQ-036 CICLOS_TIMEOUT=100, 2 samples then silence -> timeout_o=1 exactly 100 cycles after the last capture, start_o=0, valid_o=0.
REQ-037 rst pulsed after 3 of 8 captures, then a full new campaign of eight 5s -> media_ms=5 with no carry-over.
REQ-038 done_i pulsed in OCIOSO and RESULTADO, and iniciar held during COLETANDO -> no capture, no restart; counts are unaffected.
REQ-039 With AGREGADOR_MINMAX_EN undefined, the REQ-034 stimulus -> media_ms=45, min_ms=0, max_ms=0.
